// File: rtl/mb_fetch_scheduler.sv
// Macroblock raster fetch scheduler with valid/ready address handshake
// and two-bank ping-pong buffer occupancy tracking.
module mb_fetch_scheduler #(
    parameter int unsigned MACRODIM  = 16,
    parameter int unsigned IMGWIDTH  = 48,
    parameter int unsigned IMGHEIGHT = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [31:0] rd_x,
    output logic [31:0] rd_y,
    output logic        wr_bank,
    output logic        wr_last,
    output logic        mb_done,
    output logic [7:0]  mb_index,
    input  logic        bank_release,
    input  logic        bank_release_id,
    output logic [1:0]  bank_full,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [31:0] X_LAST  = 32'(MACRODIM - 4);
    localparam logic [31:0] Y_LAST  = 32'(MACRODIM - 1);
    localparam logic [31:0] XB_LAST = 32'(IMGWIDTH - MACRODIM);
    localparam logic [31:0] YB_LAST = 32'(IMGHEIGHT - MACRODIM);
    localparam logic [31:0] MB_STEP = 32'(MACRODIM);

    state_t      state_q, state_d;
    logic [31:0] xcount_q, xcount_d;
    logic [31:0] ycount_q, ycount_d;
    logic [31:0] xbase_q, xbase_d;
    logic [31:0] ybase_q, ybase_d;
    logic        wr_bank_q, wr_bank_d;
    logic [1:0]  bank_full_q, bank_full_d;
    logic [7:0]  mb_index_q, mb_index_d;
    logic        mb_done_q, mb_done_d;
    logic        frame_done_q, frame_done_d;

    logic        accept;
    logic        x_end;
    logic        y_end;
    logic        row_end;
    logic        col_end;
    logic [1:0]  rel_mask;
    logic        bank_free;

    // Handshake and datapath decode shared by next-state and outputs
    always_comb begin
        accept    = (state_q == S_FETCH) && rd_ready;
        x_end     = (xcount_q == X_LAST);
        y_end     = (ycount_q == Y_LAST);
        row_end   = (xbase_q == XB_LAST);
        col_end   = (ybase_q == YB_LAST);
        rel_mask  = 2'b00;
        if (bank_release) begin
            rel_mask[bank_release_id] = 1'b1;
        end
        bank_free = !bank_full_q[wr_bank_q] ||
                    (bank_release && (bank_release_id == wr_bank_q));
    end

    // Next-state: FSM, beat counters, MB bases and bank flags
    always_comb begin
        state_d      = state_q;
        xcount_d     = xcount_q;
        ycount_d     = ycount_q;
        xbase_d      = xbase_q;
        ybase_d      = ybase_q;
        wr_bank_d    = wr_bank_q;
        mb_index_d   = mb_index_q;
        mb_done_d    = 1'b0;
        frame_done_d = (state_q == S_DONE);
        // releases first so a same-bank set below overrides them
        bank_full_d  = bank_full_q & ~rel_mask;

        case (state_q)
            S_IDLE: begin
                // frame_done_q marks the trailing busy cycle of a frame
                if (start && !frame_done_q) begin
                    xcount_d   = '0;
                    ycount_d   = '0;
                    xbase_d    = '0;
                    ybase_d    = '0;
                    mb_index_d = '0;
                    if (bank_full_q[wr_bank_q]) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (accept) begin
                    if (!x_end) begin
                        xcount_d = xcount_q + 32'd4;
                    end else if (!y_end) begin
                        xcount_d = '0;
                        ycount_d = ycount_q + 32'd1;
                    end else begin
                        xcount_d   = '0;
                        ycount_d   = '0;
                        bank_full_d[wr_bank_q] = 1'b1;
                        wr_bank_d  = ~wr_bank_q;
                        mb_index_d = mb_index_q + 8'd1;
                        mb_done_d  = 1'b1;
                        if (row_end) begin
                            xbase_d = '0;
                            ybase_d = ybase_q + MB_STEP;
                        end else begin
                            xbase_d = xbase_q + MB_STEP;
                        end
                        if (row_end && col_end) begin
                            state_d = S_DONE;
                        end else if (bank_full_d[~wr_bank_q]) begin
                            state_d = S_WAIT;
                        end else begin
                            state_d = S_FETCH;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (bank_free) begin
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            xcount_q     <= '0;
            ycount_q     <= '0;
            xbase_q      <= '0;
            ybase_q      <= '0;
            wr_bank_q    <= 1'b0;
            bank_full_q  <= 2'b00;
            mb_index_q   <= '0;
            mb_done_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            xcount_q     <= xcount_d;
            ycount_q     <= ycount_d;
            xbase_q      <= xbase_d;
            ybase_q      <= ybase_d;
            wr_bank_q    <= wr_bank_d;
            bank_full_q  <= bank_full_d;
            mb_index_q   <= mb_index_d;
            mb_done_q    <= mb_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Outputs derive from registered state only
    always_comb begin
        rd_valid   = (state_q == S_FETCH);
        rd_x       = xbase_q + xcount_q;
        rd_y       = ybase_q + ycount_q;
        wr_last    = rd_valid && x_end && y_end;
        wr_bank    = wr_bank_q;
        mb_index   = mb_index_q;
        mb_done    = mb_done_q;
        bank_full  = bank_full_q;
        frame_done = frame_done_q;
        busy       = (state_q != S_IDLE) || frame_done_q;
    end

endmodule
